// File: rtl/layer_sequencer_pkg.sv
// accel_pkg: shared sequencer types and defaults.
// Holds the FSM state encoding, buffer address width and max pipe latency.
package accel_pkg;

  localparam int WDef       = 16;
  localparam int ABufferDef = 11;
  localparam int LMax       = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } seqState;

  // A zero latency would never emit a result, so it runs as one stage.
  function automatic logic [3:0] clampLatency(input logic [3:0] lat);
    return (lat == 4'd0) ? 4'd1 : lat;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: neuron buffer / swapper bus of the sequencer.
// master drives select, addresses, write strobe, pooling; slave receives.
interface layer_sequencer_if
  import accel_pkg::*;
#(
  parameter int ABuffer = ABufferDef
);

  logic               readBufferSelect;
  logic [ABuffer-1:0] nReadAddress;
  logic [ABuffer-1:0] nWriteAddress;
  logic               nWWrite;
  logic               doPooling;

  modport master (
    output readBufferSelect,
    output nReadAddress,
    output nWriteAddress,
    output nWWrite,
    output doPooling
  );

  modport slave (
    input readBufferSelect,
    input nReadAddress,
    input nWriteAddress,
    input nWWrite,
    input doPooling
  );

endinterface

// File: rtl/layer_sequencer_delay.sv
// valid_delay_line: token shift register with a runtime output tap.
// Ports: clk/rst, clr, validIn, tap (1..DEPTH), validOut, empty.
module valid_delay_line
  import accel_pkg::*;
#(
  parameter int DEPTH = LMax
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       validIn,
  input  logic [3:0] tap,
  output logic       validOut,
  output logic       empty
);

  logic [DEPTH-1:0] stage;
  logic [DEPTH-1:0] live;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stage <= '0;
    end else begin
      stage <= {stage[DEPTH-2:0], validIn};
    end
  end

  // Stages past the tap hold spent tokens; they never count as in flight.
  always_comb begin
    validOut = 1'b0;
    live     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      live[k] = stage[k] && (k < int'(tap));
      if (k + 1 == int'(tap)) begin
        validOut = stage[k];
      end
    end
  end

  assign empty = ~|live;

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs one layer pass (read, drain, buffer swap).
// Ports: CLK/RST, start, cfg*, busy, done, perfCycles, nBus (buffer bus).
// Define SEQ_PERF_COUNT_EN to build the perfCycles busy-cycle counter.
module layer_sequencer
  import accel_pkg::*;
#(
  parameter int W       = WDef,
  parameter int ABuffer = ABufferDef,
  parameter int LMAX    = LMax
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [ABuffer-1:0] cfgReadLen,
  input  logic [ABuffer-1:0] cfgReadBase,
  input  logic [ABuffer-1:0] cfgWriteBase,
  input  logic [3:0]         cfgLatency,
  input  logic               cfgPool,
  output logic               busy,
  output logic               done,
  output logic [31:0]        perfCycles,
  layer_sequencer_if.master  nBus
);

  if (W < 1) begin : gBadW
    $error("layer_sequencer: W must be positive");
  end

  seqState state;
  seqState nextState;

  logic [ABuffer-1:0] lenQ;
  logic [ABuffer-1:0] rdIdx;
  logic [ABuffer-1:0] resCnt;
  logic [ABuffer-1:0] readAddr;
  logic [ABuffer-1:0] writeAddr;
  logic [3:0]         latQ;
  logic               poolQ;
  logic [1:0]         grp;
  logic               sel;

  logic tokenIn;
  logic tokenOut;
  logic lineEmpty;
  logic active;
  logic result;
  logic lastRead;
  logic lastResult;
  logic wrEn;

  assign lastRead   = rdIdx == lenQ - ABuffer'(1);
  assign lastResult = resCnt == lenQ - ABuffer'(1);
  assign active     = (state == READ) || (state == DRAIN);
  assign result     = active && tokenOut;
  // Pooled layers write once per group of four; a short tail flushes.
  assign wrEn = result && (!poolQ || grp == 2'd3 || lastResult);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // An empty layer still spends one READ cycle before SWAP so that
  // start-to-done timing is uniform with non-empty layers.
  always_comb begin
    nextState = state;
    tokenIn   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nextState = READ;
      end
      READ: begin
        tokenIn = lenQ != '0;
        if (lenQ == '0) nextState = SWAP;
        else if (lastRead) nextState = DRAIN;
      end
      DRAIN: begin
        if (lineEmpty) nextState = SWAP;
      end
      SWAP: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lenQ      <= '0;
      rdIdx     <= '0;
      resCnt    <= '0;
      readAddr  <= '0;
      writeAddr <= '0;
      latQ      <= 4'd1;
      poolQ     <= 1'b0;
      grp       <= 2'd0;
      sel       <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        lenQ      <= cfgReadLen;
        readAddr  <= cfgReadBase;
        writeAddr <= cfgWriteBase;
        latQ      <= clampLatency(cfgLatency);
        poolQ     <= cfgPool;
        rdIdx     <= '0;
        resCnt    <= '0;
        grp       <= 2'd0;
      end
      if (state == READ && lenQ != '0 && !lastRead) begin
        rdIdx    <= rdIdx + ABuffer'(1);
        readAddr <= readAddr + ABuffer'(1);
      end
      if (result) begin
        resCnt <= resCnt + ABuffer'(1);
        grp    <= grp + 2'd1;
      end
      if (wrEn) begin
        writeAddr <= writeAddr + ABuffer'(1);
      end
      if (state == SWAP) begin
        sel <= ~sel;
      end
    end
  end

  valid_delay_line #(
    .DEPTH(LMAX)
  ) uDelay (
    .clk     (CLK),
    .rst     (RST),
    .clr     (state == IDLE),
    .validIn (tokenIn),
    .tap     (latQ),
    .validOut(tokenOut),
    .empty   (lineEmpty)
  );

  assign busy = state != IDLE;
  assign done = state == SWAP;

  assign nBus.readBufferSelect = sel;
  assign nBus.nReadAddress     = readAddr;
  assign nBus.nWriteAddress    = writeAddr;
  assign nBus.nWWrite          = wrEn;
  assign nBus.doPooling        = poolQ && busy;

`ifdef SEQ_PERF_COUNT_EN
  logic [31:0] busyCnt;
  logic [31:0] perfQ;

  // The SWAP cycle itself is busy, hence the +1 when publishing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busyCnt <= '0;
      perfQ   <= '0;
    end else begin
      if (state == IDLE && start) begin
        busyCnt <= '0;
      end else if (busy) begin
        busyCnt <= busyCnt + 32'd1;
      end
      if (state == SWAP) begin
        perfQ <= busyCnt + 32'd1;
      end
    end
  end

  assign perfCycles = perfQ;
`else
  assign perfCycles = '0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed scoreboard bench for layer_sequencer.
// Stimulus queues expected writes/done; a monitor pops and compares.
module tb_layer_sequencer;
  import accel_pkg::*;

  localparam int AB = 11;
`ifdef SEQ_PERF_COUNT_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  typedef struct {
    logic [AB-1:0] addr;
    int            rel;
  } wrExp;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [AB-1:0] cfgReadLen = '0;
  logic [AB-1:0] cfgReadBase = '0;
  logic [AB-1:0] cfgWriteBase = '0;
  logic [3:0]    cfgLatency = '0;
  logic          cfgPool = 1'b0;
  logic          busy;
  logic          done;
  logic [31:0]   perfCycles;

  layer_sequencer_if #(.ABuffer(AB)) nBus ();

  layer_sequencer #(
    .W(16),
    .ABuffer(AB),
    .LMAX(15)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .cfgReadLen  (cfgReadLen),
    .cfgReadBase (cfgReadBase),
    .cfgWriteBase(cfgWriteBase),
    .cfgLatency  (cfgLatency),
    .cfgPool     (cfgPool),
    .busy        (busy),
    .done        (done),
    .perfCycles  (perfCycles),
    .nBus        (nBus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int startCyc = 0;

  wrExp          wrQ[$];
  int            doneQ[$];
  logic [AB-1:0] rdQ[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic pushW(input logic [AB-1:0] a, input int r);
    wrExp e;
    e.addr = a;
    e.rel  = r;
    wrQ.push_back(e);
  endtask

  task automatic idleChecks(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_wwrite"}, nBus.nWWrite, 0);
    check({tag, "_dopool"}, nBus.doPooling, 0);
    check({tag, "_sel"}, nBus.readBufferSelect, 0);
    check({tag, "_raddr"}, nBus.nReadAddress, 0);
    check({tag, "_waddr"}, nBus.nWriteAddress, 0);
    check({tag, "_perf"}, perfCycles, 0);
  endtask

  always @(negedge CLK) begin : monitor
    wrExp e;
    int   d;
    if (!RST) begin
      if (nBus.nWWrite === 1'b1) begin
        if (wrQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected: write to %0h, expected none",
                   nBus.nWriteAddress);
        end else begin
          e = wrQ.pop_front();
          check("wr_addr", nBus.nWriteAddress, e.addr);
          check("wr_cycle", cyc - startCyc, e.rel);
        end
      end
      if (done === 1'b1) begin
        if (doneQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: done at cycle %0d, expected none",
                   cyc - startCyc);
        end else begin
          d = doneQ.pop_front();
          check("done_cycle", cyc - startCyc, d);
          check("done_busy", busy, 1);
        end
      end
    end
  end

  task automatic runLayer(input int n, input logic [AB-1:0] rb,
                          input logic [AB-1:0] wb, input logic [3:0] lat,
                          input logic pool, input logic selAfter,
                          input int perfExp, input bit poke);
    bit fin;
    fin = 1'b0;
    @(negedge CLK);
    cfgReadLen   = AB'(n);
    cfgReadBase  = rb;
    cfgWriteBase = wb;
    cfgLatency   = lat;
    cfgPool      = pool;
    start        = 1'b1;
    @(posedge CLK);
    #1;
    start    = 1'b0;
    startCyc = cyc;
    for (int k = 0; k < 60 && !fin; k++) begin
      @(negedge CLK);
      if (k == 0) check("busy_start", busy, 1);
      if (k < n && rdQ.size() > 0) check("rd_addr", nBus.nReadAddress, rdQ.pop_front());
      if (busy) check("do_pooling", nBus.doPooling, pool);
      else fin = 1'b1;
      if (poke && k == 1) begin
        start        = 1'b1;
        cfgReadBase  = 11'h050;
        cfgReadLen   = 11'd1;
        cfgWriteBase = 11'h055;
        cfgLatency   = 4'd7;
        cfgPool      = ~pool;
      end
      if (poke && k == 2) start = 1'b0;
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL timeout: busy=%0b after 60 cycles, expected 0", busy);
    end
    check("sel_after", nBus.readBufferSelect, selAfter);
    check("perf_after", perfCycles, PerfOn ? perfExp : 0);
    check("wr_pending", wrQ.size(), 0);
    check("done_pending", doneQ.size(), 0);
    rdQ.delete();
    wrQ.delete();
    doneQ.delete();
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    idleChecks("reset");
    @(negedge CLK);
    RST = 1'b0;

    // N=4 L=2, second start mid-layer must be ignored
    rdQ = '{11'h010, 11'h011, 11'h012, 11'h013};
    pushW(11'h020, 2); pushW(11'h021, 3);
    pushW(11'h022, 4); pushW(11'h023, 5);
    doneQ.push_back(7);
    runLayer(4, 11'h010, 11'h020, 4'd2, 1'b0, 1'b1, 8, 1'b1);

    // N=9 L=3 pooled: writes on results 4, 8 and the trailing 9th
    rdQ = '{11'h100, 11'h101, 11'h102, 11'h103, 11'h104,
            11'h105, 11'h106, 11'h107, 11'h108};
    pushW(11'h200, 6); pushW(11'h201, 10); pushW(11'h202, 11);
    doneQ.push_back(13);
    runLayer(9, 11'h100, 11'h200, 4'd3, 1'b1, 1'b0, 14, 1'b0);

    // N=0: no traffic, done after 2 cycles
    doneQ.push_back(1);
    runLayer(0, 11'h300, 11'h310, 4'd4, 1'b0, 1'b1, 2, 1'b0);

    // address wrap on both sides
    rdQ = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    pushW(11'h7FF, 1); pushW(11'h000, 2);
    pushW(11'h001, 3); pushW(11'h002, 4);
    doneQ.push_back(6);
    runLayer(4, 11'h7FE, 11'h7FF, 4'd1, 1'b0, 1'b0, 7, 1'b0);

    // latency 0 behaves as 1
    rdQ = '{11'h030, 11'h031};
    pushW(11'h040, 1); pushW(11'h041, 2);
    doneQ.push_back(4);
    runLayer(2, 11'h030, 11'h040, 4'd0, 1'b0, 1'b1, 5, 1'b0);

    // max latency, pooled exact group of four
    rdQ = '{11'h0A0, 11'h0A1, 11'h0A2, 11'h0A3};
    pushW(11'h0B0, 18);
    doneQ.push_back(20);
    runLayer(4, 11'h0A0, 11'h0B0, 4'd15, 1'b1, 1'b0, 21, 1'b0);

    // pooled partial group of two
    rdQ = '{11'h0C0, 11'h0C1};
    pushW(11'h0D0, 2);
    doneQ.push_back(4);
    runLayer(2, 11'h0C0, 11'h0D0, 4'd1, 1'b1, 1'b1, 5, 1'b0);

    // reset during READ at i=2 aborts the layer
    rdQ = '{11'h060, 11'h061, 11'h062};
    @(negedge CLK);
    cfgReadLen   = 11'd8;
    cfgReadBase  = 11'h060;
    cfgWriteBase = 11'h070;
    cfgLatency   = 4'd5;
    cfgPool      = 1'b1;
    start        = 1'b1;
    @(posedge CLK);
    #1;
    start    = 1'b0;
    startCyc = cyc;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("abort_rd", nBus.nReadAddress, rdQ.pop_front());
      check("abort_pool", nBus.doPooling, 1);
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    idleChecks("abort");
    @(negedge CLK);
    RST = 1'b0;
    repeat (25) @(negedge CLK);
    check("abort_idle", busy, 0);
    rdQ.delete();

    // clean layer after the abort, select restarts from 0
    rdQ = '{11'h003};
    pushW(11'h005, 1);
    doneQ.push_back(3);
    runLayer(1, 11'h003, 11'h005, 4'd1, 1'b0, 1'b1, 4, 1'b0);

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
